// File: rtl/jt10_adpcm_pkg.sv
// Shared definitions for the ADPCM-A gain slot scheduler.
//
// Contents:
//   NCH_DEF / LAT_DEF / AW_DEF  default channel count, return latency and
//                               accumulator width
//   ch_t                        channel / slot index type
//   LRACL_*                     bit positions inside an lracl byte
//   next_slot()                 slot counter successor with wrap at n-1
package jt10_adpcm_pkg;

  localparam int NCH_DEF = 6;
  localparam int LAT_DEF = 2;
  localparam int AW_DEF  = 19;

  typedef logic [2:0] ch_t;

  // lracl byte layout: left enable, right enable, attenuation level
  localparam int LRACL_L      = 7;
  localparam int LRACL_R      = 6;
  localparam int LRACL_LVL_HI = 5;
  localparam int LRACL_LVL_LO = 0;

  // Successor of a slot index in a ring of n slots
  function automatic ch_t next_slot(input ch_t c, input int n);
    if (int'(c) >= n - 1) return '0;
    return c + 3'd1;
  endfunction

endpackage

// File: rtl/jt10_adpcm_sat.sv
// Signed saturating narrower.
//
// Ports:
//   din_i   IW-bit signed input
//   dout_o  OW-bit signed output, clamped to the OW-bit two's complement range
module jt10_adpcm_sat #(
  parameter int IW = 19,
  parameter int OW = 16
) (
  input  logic signed [IW-1:0] din_i,
  output logic signed [OW-1:0] dout_o
);

  localparam logic signed [IW-1:0] MAXV = {{(IW-OW+1){1'b0}}, {(OW-1){1'b1}}};
  localparam logic signed [IW-1:0] MINV = {{(IW-OW+1){1'b1}}, {(OW-1){1'b0}}};

  // Clamp anything outside the output range to the nearest extreme,
  // otherwise just drop the redundant sign bits
  always_comb begin
    if (din_i > MAXV) begin
      dout_o = {1'b0, {(OW-1){1'b1}}};
    end else if (din_i < MINV) begin
      dout_o = {1'b1, {(OW-1){1'b0}}};
    end else begin
      dout_o = din_i[OW-1:0];
    end
  end

endmodule

// File: rtl/jt10_adpcm_gain_sched.sv
// Time-slot controller for the six-channel ADPCM-A gain datapath.
//
// Ports:
//   clk, rst_n           clock, synchronous active-low reset
//   cen                  clock enable, one slot per enabled cycle
//   wr_en/wr_ch/wr_data  CPU lracl write (last write per channel wins)
//   slot_ch              channel currently at the datapath injection stage
//   we/lracl_out         one-cycle lracl injection for slot_ch
//   pcm_l_in/pcm_r_in    per-channel gain results, arriving LAT slots late
//   mix_l/mix_r          saturated stereo sum of one full frame
//   mix_valid            one-cycle pulse when mix_l/mix_r update
//   pend                 per-channel write-pending flags
module jt10_adpcm_gain_sched
  import jt10_adpcm_pkg::*;
#(
  parameter int NCH = NCH_DEF,
  parameter int LAT = LAT_DEF,
  parameter int AW  = AW_DEF
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           cen,
  input  logic           wr_en,
  input  logic [2:0]     wr_ch,
  input  logic [7:0]     wr_data,
  output logic [2:0]     slot_ch,
  output logic           we,
  output logic [7:0]     lracl_out,
  input  logic [15:0]    pcm_l_in,
  input  logic [15:0]    pcm_r_in,
  output logic [15:0]    mix_l,
  output logic [15:0]    mix_r,
  output logic           mix_valid,
  output logic [NCH-1:0] pend
);

  ch_t                  slot_q, slot_d;
  logic                 we_q, we_d;
  logic [7:0]           lracl_q, lracl_d;
  logic [7:0]           data_q [NCH];
  logic [7:0]           data_d [NCH];
  logic [NCH-1:0]       pend_q, pend_d;
  ch_t                  ret_q [LAT];
  ch_t                  ret_d [LAT];
  logic signed [AW-1:0] acc_l_q, acc_l_d, acc_r_q, acc_r_d;
  logic [15:0]          mix_l_q, mix_l_d, mix_r_q, mix_r_d;
  logic                 mix_valid_q, mix_valid_d;
  logic                 seen_q, seen_d;

  ch_t                  next_ch;
  ch_t                  ret_ch;
  logic signed [AW-1:0] pcm_l_ext, pcm_r_ext;
  logic signed [AW-1:0] sum_l, sum_r;
  logic signed [15:0]   sat_l, sat_r;

  // The issue decision looks one slot ahead so that a registered we lines
  // up with the slot_ch value it belongs to. ret_ch is the slot whose
  // result is on pcm_*_in right now; a zero there restarts the frame sum.
  assign next_ch   = next_slot(slot_q, NCH);
  assign ret_ch    = ret_q[LAT-1];
  assign pcm_l_ext = {{(AW-16){pcm_l_in[15]}}, pcm_l_in};
  assign pcm_r_ext = {{(AW-16){pcm_r_in[15]}}, pcm_r_in};
  assign sum_l     = ((ret_ch == '0) ? '0 : acc_l_q) + pcm_l_ext;
  assign sum_r     = ((ret_ch == '0) ? '0 : acc_r_q) + pcm_r_ext;

  jt10_adpcm_sat #(.IW(AW), .OW(16)) u_sat_l (.din_i(sum_l), .dout_o(sat_l));
  jt10_adpcm_sat #(.IW(AW), .OW(16)) u_sat_r (.din_i(sum_r), .dout_o(sat_r));

  // Next-state logic. Everything slot-related only moves on cen; CPU
  // writes are captured on every clock. A write landing in the same cycle
  // that issues its channel is applied after the issue, so the old value
  // goes out and the new one stays pending for the next pass.
  always_comb begin
    slot_d      = slot_q;
    we_d        = 1'b0;
    lracl_d     = lracl_q;
    pend_d      = pend_q;
    data_d      = data_q;
    ret_d       = ret_q;
    acc_l_d     = acc_l_q;
    acc_r_d     = acc_r_q;
    mix_l_d     = mix_l_q;
    mix_r_d     = mix_r_q;
    mix_valid_d = 1'b0;
    seen_d      = seen_q;
    if (cen) begin
      slot_d   = next_ch;
      ret_d[0] = slot_q;
      for (int i = 1; i < LAT; i++) ret_d[i] = ret_q[i-1];
      acc_l_d = sum_l;
      acc_r_d = sum_r;
      if (ret_ch == '0) seen_d = 1'b1;
      if ((int'(ret_ch) == NCH - 1) && seen_q) begin
        mix_l_d     = sat_l;
        mix_r_d     = sat_r;
        mix_valid_d = 1'b1;
      end
      if (pend_q[next_ch]) begin
        we_d            = 1'b1;
        lracl_d         = data_q[next_ch];
        pend_d[next_ch] = 1'b0;
      end
    end
    if (wr_en && (int'(wr_ch) < NCH)) begin
      pend_d[wr_ch] = 1'b1;
      data_d[wr_ch] = wr_data;
    end
  end

  // State registers; reset discards queued writes and any partial frame
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      slot_q      <= '0;
      we_q        <= 1'b0;
      lracl_q     <= '0;
      data_q      <= '{default: '0};
      pend_q      <= '0;
      ret_q       <= '{default: '0};
      acc_l_q     <= '0;
      acc_r_q     <= '0;
      mix_l_q     <= '0;
      mix_r_q     <= '0;
      mix_valid_q <= 1'b0;
      seen_q      <= 1'b0;
    end else begin
      slot_q      <= slot_d;
      we_q        <= we_d;
      lracl_q     <= lracl_d;
      data_q      <= data_d;
      pend_q      <= pend_d;
      ret_q       <= ret_d;
      acc_l_q     <= acc_l_d;
      acc_r_q     <= acc_r_d;
      mix_l_q     <= mix_l_d;
      mix_r_q     <= mix_r_d;
      mix_valid_q <= mix_valid_d;
      seen_q      <= seen_d;
    end
  end

  assign slot_ch   = slot_q;
  assign we        = we_q;
  assign lracl_out = lracl_q;
  assign mix_l     = mix_l_q;
  assign mix_r     = mix_r_q;
  assign mix_valid = mix_valid_q;
  assign pend      = pend_q;

endmodule
